// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the UART transmit arbiter slice.
//               Holds the FSM state encoding, the UART byte width and the
//               round-robin pick helper used by rr_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;

    // Widest requester vector the pick helper handles.
    localparam int RR_MAX_REQ = 8;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOAD     = 3'd1;
    localparam logic [2:0] ST_KICK     = 3'd2;
    localparam logic [2:0] ST_WAIT_ON  = 3'd3;
    localparam logic [2:0] ST_WAIT_OFF = 3'd4;
    localparam logic [2:0] ST_GAP      = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_LOAD     = ST_LOAD,
        S_KICK     = ST_KICK,
        S_WAIT_ON  = ST_WAIT_ON,
        S_WAIT_OFF = ST_WAIT_OFF,
        S_GAP      = ST_GAP
    } state_t;

    // One-hot grant for the first set bit of valid at or after ptr, wrapping
    // modulo n. Bits at or above n are never granted.
    function automatic logic [RR_MAX_REQ-1:0] rr_pick(
        input logic [RR_MAX_REQ-1:0] valid,
        input logic [2:0]            ptr,
        input int unsigned           n
    );
        logic [RR_MAX_REQ-1:0] g;
        logic                  found;
        logic [2:0]            idx;
        g     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < RR_MAX_REQ; i++) begin
            if ((i < n) && !found) begin
                idx = 3'((32'(ptr) + i) % n);
                if (valid[idx]) begin
                    g[idx] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin picker with a registered priority pointer.
//               o_pick is a combinational one-hot choice among i_req starting
//               at the pointer; on i_release the pointer moves to the slot
//               after i_owner (explicit modulo N wrap).
// Ports       : clk, rst         - clock, asynchronous active-high reset
//               i_req     [N]    - request vector
//               i_release        - owner has finished with the resource
//               i_owner   [N]    - one-hot current owner
//               o_pick    [N]    - one-hot pick (zero when no request)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_req,
    input  logic         i_release,
    input  logic [N-1:0] i_owner,
    output logic [N-1:0] o_pick
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0]      r_ptr;
    logic [PTR_W-1:0]      w_owner_idx;
    logic [PTR_W-1:0]      w_ptr_nxt;
    logic [RR_MAX_REQ-1:0] w_req8;
    logic [RR_MAX_REQ-1:0] w_pick8;

    always_comb begin
        w_req8         = '0;
        w_req8[N-1:0]  = i_req;
    end

    assign w_pick8 = rr_pick(w_req8, 3'(r_ptr), N);
    assign o_pick  = w_pick8[N-1:0];

    generate
        if (N < RR_MAX_REQ) begin : g_hi_bits
            // Upper pick bits are always zero because requests there are zero.
            logic w_unused_hi;
            assign w_unused_hi = |w_pick8[RR_MAX_REQ-1:N];
        end
    endgenerate

    always_comb begin
        w_owner_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (i_owner[i]) begin
                w_owner_idx = PTR_W'(i);
            end
        end
    end

    // N need not be a power of two, so wrap explicitly.
    assign w_ptr_nxt = (w_owner_idx == PTR_W'(N-1)) ? '0 : (w_owner_idx + PTR_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_release) begin
            r_ptr <= w_ptr_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Shares one UART transmit core among NUM_REQ byte streams.
//               Packet-granular round-robin; per byte it accepts data, kicks
//               the core with a one-cycle DE, holds the byte until the core's
//               busy falls, then enforces an idle gap before the next kick.
// Ports       : CLK, RST              - clock, async active-high reset
//               iVALID/iDATA/iLAST    - per-requester byte stream
//               oREADY                - one-cycle accept pulse (<=1 bit)
//               oGRANT                - one-hot line owner, zero when idle
//               oTX_DE/oTX_DATA       - core data-enable kick and data word
//               iTX_BUSY              - core busy flag
//               oTIMEOUT              - pulse when a kick gets no busy
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int DATA_WIDTH   = UART_DATA_WIDTH,
    parameter int BUSY_TIMEOUT = 15,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            iVALID,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] iDATA,
    input  logic [NUM_REQ-1:0]            iLAST,
    output logic [NUM_REQ-1:0]            oREADY,
    output logic [NUM_REQ-1:0]            oGRANT,
    output logic                          oTX_DE,
    output logic [DATA_WIDTH-1:0]         oTX_DATA,
    input  logic                          iTX_BUSY,
    output logic                          oTIMEOUT
);

    localparam int CNT_MAX = (BUSY_TIMEOUT > GAP_CYCLES) ? BUSY_TIMEOUT : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [NUM_REQ-1:0]    r_grant;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_last;

    logic [NUM_REQ-1:0]    w_pick;
    logic [NUM_REQ-1:0]    w_ready;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_sel_valid;
    logic                  w_sel_last;
    logic                  w_take_grant;
    logic                  w_accept;
    logic                  w_release;
    logic                  w_de;
    logic                  w_timeout;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .clk       (CLK),
        .rst       (RST),
        .i_req     (iVALID),
        .i_release (w_release),
        .i_owner   (r_grant),
        .o_pick    (w_pick)
    );

    // Grant is one-hot, so a simple priority loop acts as the owner mux.
    always_comb begin
        w_sel_data  = '0;
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r_grant[k]) begin
                w_sel_data  = iDATA[k*DATA_WIDTH +: DATA_WIDTH];
                w_sel_valid = iVALID[k];
                w_sel_last  = iLAST[k];
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_take_grant = 1'b0;
        w_accept     = 1'b0;
        w_release    = 1'b0;
        w_de         = 1'b0;
        w_timeout    = 1'b0;
        w_ready      = '0;
        case (r_state)
            S_IDLE: begin
                if (|iVALID) begin
                    w_take_grant = 1'b1;
                    w_state_nxt  = S_LOAD;
                end
            end
            S_LOAD: begin
                // Accept is held off while the core is still busy (e.g. a
                // frame left running across reset) so the kick never overlaps.
                if (w_sel_valid && !iTX_BUSY) begin
                    w_accept    = 1'b1;
                    w_ready     = r_grant;
                    w_state_nxt = S_KICK;
                end
            end
            S_KICK: begin
                w_de        = 1'b1;
                w_state_nxt = S_WAIT_ON;
            end
            S_WAIT_ON: begin
                if (iTX_BUSY) begin
                    w_state_nxt = S_WAIT_OFF;
                end else if (r_cnt == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_GAP;
                end
            end
            S_WAIT_OFF: begin
                if (!iTX_BUSY) begin
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    if (r_last) begin
                        w_release   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_LOAD;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_grant <= '0;
            r_data  <= '1;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            // One counter serves both the busy timeout and the gap; it
            // restarts on every state change.
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if ((r_state == S_WAIT_ON) || (r_state == S_GAP)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_take_grant) begin
                r_grant <= w_pick;
            end else if (w_release) begin
                r_grant <= '0;
            end

            if (w_accept) begin
                r_data <= w_sel_data;
                r_last <= w_sel_last;
            end
        end
    end

    assign oREADY   = w_ready;
    assign oGRANT   = r_grant;
    assign oTX_DE   = w_de;
    assign oTX_DATA = r_data;
    assign oTIMEOUT = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter. Requesters are fed
//               from per-requester byte queues; a packet-level round-robin
//               model predicts the order of bytes on the line; a simple
//               busy model emulates the UART core.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NR  = 2;
    localparam int TO  = 15;
    localparam int GAP = 2;

    logic            CLK;
    logic            RST;
    logic [NR-1:0]   iVALID;
    logic [NR*8-1:0] iDATA;
    logic [NR-1:0]   iLAST;
    logic [NR-1:0]   oREADY;
    logic [NR-1:0]   oGRANT;
    logic            oTX_DE;
    logic [7:0]      oTX_DATA;
    logic            iTX_BUSY;
    logic            oTIMEOUT;

    uart_tx_arbiter #(
        .NUM_REQ      (NR),
        .DATA_WIDTH   (8),
        .BUSY_TIMEOUT (TO),
        .GAP_CYCLES   (GAP)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .iVALID   (iVALID),
        .iDATA    (iDATA),
        .iLAST    (iLAST),
        .oREADY   (oREADY),
        .oGRANT   (oGRANT),
        .oTX_DE   (oTX_DE),
        .oTX_DATA (oTX_DATA),
        .iTX_BUSY (iTX_BUSY),
        .oTIMEOUT (oTIMEOUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Requester queues: each entry is {last, byte}.
    // ------------------------------------------------------------------
    int drv_q   [NR][$];
    int model_q [NR][$];
    int stall_cnt [NR];
    bit force_stall [NR];
    bit rand_stall;
    int model_ptr;

    typedef struct {
        logic [7:0] d;
        int         owner;
    } exp_t;
    exp_t exp_q[$];

    // Busy model state
    bit busy_en;
    int frame_len;
    int rise_in;
    int busy_left;

    // Monitor state
    int         cyc;
    int         kick_cyc;
    bit         to_armed;
    logic [7:0] held;
    int         ready_cnt [NR];
    int         kick_cnt;
    int         to_cnt;

    task automatic push_byte(input int k, input logic [7:0] d, input logic last);
        drv_q[k].push_back(int'({last, d}));
        model_q[k].push_back(int'({last, d}));
    endtask

    // Packet-level round robin: among requesters with packets pending, the
    // first at or after the pointer sends a whole packet, pointer moves past it.
    function automatic void plan();
        int k;
        int c;
        int v;
        while (1) begin
            k = -1;
            for (int i = 0; i < NR; i++) begin
                c = (model_ptr + i) % NR;
                if (k < 0 && model_q[c].size() > 0) k = c;
            end
            if (k < 0) break;
            do begin
                v = model_q[k].pop_front();
                exp_q.push_back('{d: v[7:0], owner: k});
            end while (!v[8]);
            model_ptr = (k + 1) % NR;
        end
    endfunction

    function automatic int pending();
        int n;
        n = 0;
        for (int k = 0; k < NR; k++) n += drv_q[k].size();
        return n;
    endfunction

    // ------------------------------------------------------------------
    // Requester driver: handshake seen at negedge completes at the posedge.
    // ------------------------------------------------------------------
    initial begin : p_drv
        logic [NR-1:0] rdy;
        int            hv;
        iVALID = '0;
        iDATA  = '0;
        iLAST  = '0;
        forever begin
            @(negedge CLK);
            rdy = oREADY;
            @(posedge CLK);
            #1;
            for (int k = 0; k < NR; k++) begin
                if (rdy[k] && drv_q[k].size() > 0) begin
                    hv = drv_q[k].pop_front();
                    if (!hv[8]) begin
                        if (force_stall[k]) stall_cnt[k] = 20;
                        else if (rand_stall) stall_cnt[k] = $urandom_range(0, 4);
                    end
                end else if (stall_cnt[k] > 0) begin
                    stall_cnt[k]--;
                end
                if (drv_q[k].size() > 0) begin
                    hv = drv_q[k][0];
                    iVALID[k]       = (stall_cnt[k] == 0);
                    iDATA[k*8 +: 8] = hv[7:0];
                    iLAST[k]        = hv[8];
                end else begin
                    iVALID[k]       = 1'b0;
                    iDATA[k*8 +: 8] = 8'h00;
                    iLAST[k]        = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Core busy model: busy rises 2 cycles after the kick, lasts frame_len.
    // ------------------------------------------------------------------
    initial begin : p_busy
        logic de;
        iTX_BUSY = 1'b0;
        forever begin
            @(negedge CLK);
            de = oTX_DE;
            @(posedge CLK);
            #1;
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) iTX_BUSY = 1'b0;
            end
            if (rise_in > 0) begin
                rise_in--;
                if (rise_in == 0) begin
                    iTX_BUSY  = 1'b1;
                    busy_left = frame_len;
                end
            end
            if (de && busy_en) rise_in = 1;
        end
    end

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    initial begin : p_mon
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                cyc++;
                check_eq("ready_within_grant", 32'(oREADY & ~oGRANT), 0);
                check_eq("ready_onehot", 32'($countones(oREADY) <= 1), 1);
                check_eq("timeout_pulse", 32'(oTIMEOUT),
                         32'(to_armed && ((cyc - kick_cyc) == TO)));
                if (oTIMEOUT) begin
                    to_armed = 1'b0;
                    to_cnt++;
                end
                if (iTX_BUSY) check_eq("data_hold", 32'(oTX_DATA), 32'(held));
                for (int k = 0; k < NR; k++) ready_cnt[k] += int'(oREADY[k]);
                if (oTX_DE) begin
                    kick_cnt++;
                    if (exp_q.size() == 0) begin
                        check_eq("kick_expected", 32'(exp_q.size()), 1);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("kick_data", 32'(oTX_DATA), 32'(e.d));
                        check_eq("kick_owner", 32'(oGRANT), 32'(1) << e.owner);
                    end
                    held     = oTX_DATA;
                    kick_cyc = cyc;
                    to_armed = !busy_en;
                end
            end
        end
    end

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || pending() > 0 || oGRANT != '0 || iTX_BUSY) && n < 4000) begin
            @(negedge CLK);
            n++;
        end
        check_eq({tag, "_left"}, 32'(exp_q.size() + pending()), 0);
        check_eq({tag, "_grant_idle"}, 32'(oGRANT), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_de"},      32'(oTX_DE),   0);
        check_eq({tag, "_data"},    32'(oTX_DATA), 32'h FF);
        check_eq({tag, "_grant"},   32'(oGRANT),   0);
        check_eq({tag, "_ready"},   32'(oREADY),   0);
        check_eq({tag, "_timeout"}, 32'(oTIMEOUT), 0);
    endtask

    initial begin : p_watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin : p_main
        int r0;
        int r1;
        int kc;
        int tc;
        int n;
        int np;
        int len;
        RST        = 1'b1;
        busy_en    = 1'b1;
        frame_len  = 40;
        rand_stall = 1'b0;
        model_ptr  = 0;
        for (int k = 0; k < NR; k++) begin
            stall_cnt[k]   = 0;
            force_stall[k] = 1'b0;
        end
        repeat (3) @(negedge CLK);
        #1;
        check_reset_outputs("reset");
        @(negedge CLK);
        #3 RST = 1'b0;

        // Single byte
        r0 = ready_cnt[0];
        kc = kick_cnt;
        push_byte(0, 8'hA5, 1'b1);
        plan();
        drain("single");
        check_eq("single_ready0", 32'(ready_cnt[0] - r0), 1);
        check_eq("single_kicks", 32'(kick_cnt - kc), 1);

        // Packet lock: req1 shows up mid-packet of req0
        push_byte(0, 8'h11, 1'b0);
        push_byte(0, 8'h22, 1'b0);
        push_byte(0, 8'h33, 1'b1);
        plan();
        repeat (10) @(negedge CLK);
        push_byte(1, 8'h22, 1'b1);
        plan();
        drain("lock");

        // Round robin with both requesters continuously valid
        for (int i = 0; i < 4; i++) begin
            push_byte(0, 8'($urandom_range(0, 255)), 1'b1);
            push_byte(1, 8'($urandom_range(0, 255)), 1'b1);
        end
        plan();
        drain("rr");

        // Timeout: core never answers
        busy_en = 1'b0;
        tc = to_cnt;
        push_byte(1, 8'h3C, 1'b1);
        plan();
        drain("timeout");
        check_eq("timeout_count", 32'(to_cnt - tc), 1);
        busy_en = 1'b1;

        // Stall mid-packet while req1 waits
        force_stall[0] = 1'b1;
        r0 = ready_cnt[0];
        r1 = ready_cnt[1];
        push_byte(0, 8'h5E, 1'b0);
        push_byte(0, 8'hE5, 1'b1);
        push_byte(1, 8'h77, 1'b1);
        plan();
        n = 0;
        while (ready_cnt[0] == r0 && n < 500) begin
            @(negedge CLK);
            n++;
        end
        repeat (10) @(negedge CLK);
        check_eq("stall_grant", 32'(oGRANT), 32'h1);
        check_eq("stall_no_ready1", 32'(ready_cnt[1] - r1), 0);
        drain("stall");
        force_stall[0] = 1'b0;

        // Randomized packets, stalls, frame lengths and timeouts
        rand_stall = 1'b1;
        for (int r = 0; r < 6; r++) begin
            frame_len = $urandom_range(3, 30);
            busy_en   = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < NR; k++) begin
                np = $urandom_range(0, 2);
                for (int p = 0; p < np; p++) begin
                    len = $urandom_range(1, 3);
                    for (int b = 0; b < len; b++)
                        push_byte(k, 8'($urandom_range(0, 255)), b == len - 1);
                end
            end
            plan();
            drain("random");
        end
        rand_stall = 1'b0;
        busy_en    = 1'b1;
        frame_len  = 40;

        // Reset during WAIT_OFF: move pointer to req1 first
        push_byte(0, 8'h01, 1'b1);
        plan();
        drain("pre_reset");
        push_byte(1, 8'h5A, 1'b1);
        plan();
        n = 0;
        while (!iTX_BUSY && n < 500) begin
            @(negedge CLK);
            n++;
        end
        check_eq("reset_setup_busy", 32'(iTX_BUSY), 1);
        #2 RST = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        for (int k = 0; k < NR; k++) begin
            drv_q[k].delete();
            model_q[k].delete();
            stall_cnt[k] = 0;
        end
        exp_q.delete();
        model_ptr = 0;
        rise_in   = 0;
        busy_left = 0;
        iTX_BUSY  = 1'b0;
        iVALID    = '0;
        to_armed  = 1'b0;
        repeat (2) @(negedge CLK);
        #3 RST = 1'b0;
        push_byte(1, 8'h77, 1'b1);
        push_byte(0, 8'h66, 1'b1);
        plan();
        drain("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
